fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_defines.sv | 8 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared RISC-V widths and the default boot address used by the front end.
package riscv_defines;

  localparam int unsigned RISCV_WORD_WIDTH = 32;
  localparam int unsigned RISCV_ADDR_WIDTH = 32;
  localparam logic [RISCV_ADDR_WIDTH-1:0] RISCV_BOOT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched {address, word} pairs.
// It accepts a push while full if a pop happens in the same cycle. Flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  assign data_o  = mem_q[rd_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word fetches, buffers the in-order responses and
// presents them to the decoder. Redirects turn every in-flight response stale.
module fetch_stage
  import riscv_defines::*;
#(
  parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR  = RISCV_BOOT_ADDR,
  parameter int unsigned                 FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        instr_req_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                        instr_gnt_i,
  input  logic                        instr_rvalid_i,
  input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
  output logic [RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o_dec,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  input  logic                        multi_cycle_i,
  output logic                        cycle_counter_o,
  input  logic                        redirect_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] redirect_addr_i
);

  localparam int unsigned AW = RISCV_ADDR_WIDTH;
  localparam int unsigned WW = RISCV_WORD_WIDTH;
  localparam int unsigned EW = WW + AW;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [AW-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redirect_target;
  logic [CW-1:0] outstanding_q, outstanding_d, stale_q, stale_d, fifo_count;
  logic          cycle_q, cycle_d;
  logic          grant, rsp, rsp_keep, fire, hold, pop;
  logic          fifo_empty;
  logic [EW-1:0] fifo_wdata, fifo_rdata;
  logic [CW:0]   inflight;

  assign redirect_target = redirect_addr_i & ~AW'(3);
  assign inflight        = {1'b0, outstanding_q} + {1'b0, fifo_count};

  assign instr_req_o  = !rst && !redirect_i && (inflight < {1'b0, DEPTH_C});
  assign instr_addr_o = pc_q;

  // A grant seen during a redirect still belongs to an issued request, so it is counted as stale.
  assign grant    = instr_gnt_i && (instr_req_o || redirect_i);
  assign rsp      = instr_rvalid_i && (outstanding_q != '0);
  assign rsp_keep = rsp && (stale_q == '0) && !redirect_i;

  assign fire = instr_valid_o && instr_ready_i && !redirect_i;
  assign hold = fire && !cycle_q && multi_cycle_i;
  assign pop  = fire && !hold;

  always_comb begin
    outstanding_d = outstanding_q;
    if (grant && !rsp && (outstanding_q != DEPTH_C)) outstanding_d = outstanding_q + CW'(1);
    else if (rsp && !grant)                           outstanding_d = outstanding_q - CW'(1);
  end

  always_comb begin
    stale_d = stale_q;
    if (redirect_i)                  stale_d = outstanding_d;
    else if (rsp && stale_q != '0)   stale_d = stale_q - CW'(1);
  end

  // rsp_pc tracks the address of the next non-stale response, which lets the FIFO store addresses.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    if (redirect_i) begin
      pc_d     = redirect_target;
      rsp_pc_d = redirect_target;
    end else begin
      if (grant)    pc_d     = pc_q + AW'(4);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + AW'(4);
    end
  end

  always_comb begin
    cycle_d = cycle_q;
    if (redirect_i) cycle_d = 1'b0;
    else if (hold)  cycle_d = 1'b1;
    else if (pop)   cycle_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= BOOT_ADDR;
      rsp_pc_q      <= BOOT_ADDR;
      outstanding_q <= '0;
      stale_q       <= '0;
      cycle_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      cycle_q       <= cycle_d;
    end
  end

  assign fifo_wdata = {rsp_pc_q, instr_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (rsp_keep),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign instr_valid_o    = !fifo_empty;
  assign instr_o          = fifo_empty ? '0 : fifo_rdata[WW-1:0];
  assign instr_addr_o_dec = fifo_empty ? '0 : fifo_rdata[EW-1:WW];
  assign cycle_counter_o  = cycle_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory model plus an architectural scoreboard
// of expected fetch addresses, buffered words and the decode cycle counter.
module tb_fetch_stage;
  import riscv_defines::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o_dec;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        multi_cycle_i;
  logic        cycle_counter_o;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;

  fetch_stage #(
    .BOOT_ADDR  (BOOT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_req_o      (instr_req_o),
    .instr_addr_o     (instr_addr_o),
    .instr_gnt_i      (instr_gnt_i),
    .instr_rvalid_i   (instr_rvalid_i),
    .instr_rdata_i    (instr_rdata_i),
    .instr_o          (instr_o),
    .instr_addr_o_dec (instr_addr_o_dec),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .multi_cycle_i    (multi_cycle_i),
    .cycle_counter_o  (cycle_counter_o),
    .redirect_i       (redirect_i),
    .redirect_addr_i  (redirect_addr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];
  logic [31:0] fifo_m[$];
  logic [31:0] fetch_pc_m;
  bit          cyc_m;
  int          cycle_no, checks, errors, consumed;
  int          gnt_pct, lat_min, lat_max;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int lat_pick();
    return lat_min + int'($urandom_range(lat_max - lat_min));
  endfunction

  // One clock of stimulus: memory responses, scoreboard comparisons, then model update at the edge.
  task automatic drive_cycle(input bit redir, input logic [31:0] raddr, input bit rdy,
                             input bit mc, input bit force_gnt);
    bit   exp_valid, exp_req, rv, g;
    req_t e;
    redirect_i      = redir;
    redirect_addr_i = raddr;
    instr_ready_i   = rdy;
    multi_cycle_i   = mc;
    rv              = (pend.size() > 0) && (pend[0].due <= cycle_no);
    instr_rvalid_i  = rv;
    instr_rdata_i   = rv ? word_of(pend[0].addr) : $urandom;
    instr_gnt_i     = 1'b0;
    #1;
    exp_valid = fifo_m.size() > 0;
    exp_req   = !redir && ((pend.size() + fifo_m.size()) < DEPTH);
    checks++;
    if (instr_valid_o !== exp_valid) begin
      errors++;
      $display("[TB] FAIL valid @%0d: got %b expected %b", cycle_no, instr_valid_o, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (instr_addr_o_dec !== fifo_m[0]) begin
        errors++;
        $display("[TB] FAIL addr_dec @%0d: got %h expected %h", cycle_no, instr_addr_o_dec, fifo_m[0]);
      end
      checks++;
      if (instr_o !== word_of(fifo_m[0])) begin
        errors++;
        $display("[TB] FAIL instr @%0d: got %h expected %h", cycle_no, instr_o, word_of(fifo_m[0]));
      end
    end
    checks++;
    if (cycle_counter_o !== cyc_m) begin
      errors++;
      $display("[TB] FAIL cycle_counter @%0d: got %b expected %b", cycle_no, cycle_counter_o, cyc_m);
    end
    checks++;
    if (instr_req_o !== exp_req) begin
      errors++;
      $display("[TB] FAIL req @%0d: got %b expected %b", cycle_no, instr_req_o, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (instr_addr_o !== fetch_pc_m) begin
        errors++;
        $display("[TB] FAIL req_addr @%0d: got %h expected %h", cycle_no, instr_addr_o, fetch_pc_m);
      end
    end
    g = force_gnt || (exp_req && ($urandom_range(99) < gnt_pct));
    instr_gnt_i = g;
    @(posedge clk);
    cycle_no++;
    if (rv) e = pend.pop_front();
    if (redir) begin
      fifo_m.delete();
      cyc_m = 1'b0;
      if (g) pend.push_back('{fetch_pc_m, cycle_no + lat_pick(), 1'b1});
      foreach (pend[i]) pend[i].stale = 1'b1;
      fetch_pc_m = {raddr[31:2], 2'b00};
    end else begin
      if (exp_valid && rdy) begin
        if (!cyc_m && mc) cyc_m = 1'b1;
        else begin
          void'(fifo_m.pop_front());
          cyc_m = 1'b0;
          consumed++;
        end
      end
      if (rv && !e.stale) fifo_m.push_back(e.addr);
      if (g) begin
        pend.push_back('{fetch_pc_m, cycle_no + lat_pick(), 1'b0});
        fetch_pc_m += 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    instr_gnt_i     = 1'b0;
    instr_rvalid_i  = 1'b0;
    instr_rdata_i   = '0;
    instr_ready_i   = 1'b0;
    multi_cycle_i   = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
  endtask

  task automatic model_reset();
    pend.delete();
    fifo_m.delete();
    fetch_pc_m = BOOT;
    cyc_m      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1;
    checks++;
    if (instr_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", instr_req_o); end
    checks++;
    if (instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid_o); end
    checks++;
    if (cycle_counter_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_cycle: got %b expected 0", cycle_counter_o); end
    checks++;
    if (instr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", instr_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int start;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    start = consumed;
    for (int i = 0; i < 24; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (consumed - start < 15) begin
      errors++;
      $display("[TB] FAIL stream_throughput: got %0d words expected at least 15", consumed - start);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (instr_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b expected 1", instr_valid_o); end
    checks++;
    if (instr_req_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_req: got %b expected 0", instr_req_o); end
    for (int i = 0; i < 12; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_multicycle();
    logic [31:0] held;
    bit          found;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (instr_valid_o && !cycle_counter_o) found = 1'b1;
      else drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL mc_setup: got no valid word expected one within 20 cycles"); end
    held = instr_addr_o_dec;
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (cycle_counter_o !== 1'b1) begin errors++; $display("[TB] FAIL mc_second_cycle: got %b expected 1", cycle_counter_o); end
    checks++;
    if (instr_addr_o_dec !== held) begin errors++; $display("[TB] FAIL mc_hold: got %h expected %h", instr_addr_o_dec, held); end
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (cycle_counter_o !== 1'b0) begin errors++; $display("[TB] FAIL mc_clear: got %b expected 0", cycle_counter_o); end
    checks++;
    if (instr_addr_o_dec !== held + 32'd4) begin
      errors++;
      $display("[TB] FAIL mc_next: got %h expected %h", instr_addr_o_dec, held + 32'd4);
    end
    lat_max = 2; gnt_pct = 70;
    for (int i = 0; i < 60; i++)
      drive_cycle(1'b0, '0, $urandom_range(99) < 75, $urandom_range(99) < 40, 1'b0);
  endtask

  task automatic first_valid_check(input string name, input logic [31:0] expect_addr);
    bit          found;
    logic [31:0] first;
    found = 1'b0;
    first = '0;
    for (int i = 0; i < 30 && !found; i++) begin
      #1;
      if (instr_valid_o) begin found = 1'b1; first = instr_addr_o_dec; end
      else drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (!found || first !== expect_addr) begin
      errors++;
      $display("[TB] FAIL %s: got %h (found %b) expected %h", name, first, found, expect_addr);
    end
  endtask

  task automatic test_redirect();
    gnt_pct = 0; lat_min = 0; lat_max = 2;
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    gnt_pct = 100; lat_min = 5; lat_max = 5;
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    lat_min = 0; lat_max = 2;
    drive_cycle(1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid_after: got %b expected 0", instr_valid_o); end
    first_valid_check("redir_first_addr", 32'h0000_0100);
    for (int i = 0; i < 15; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_redirect_collide();
    bit found;
    gnt_pct = 50; lat_min = 0; lat_max = 0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (pend.size() == 1 && pend[0].due <= cycle_no) begin
        drive_cycle(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b1);
        found = 1'b1;
      end else begin
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL collide_setup: got no rvalid slot expected one within 60 cycles"); end
    #1;
    checks++;
    if (instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL collide_valid_after: got %b expected 0", instr_valid_o); end
    gnt_pct = 100;
    first_valid_check("collide_first_addr", 32'h0000_0200);
    for (int i = 0; i < 15; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    gnt_pct = 100; lat_min = 0; lat_max = 1;
    drive_cycle(1'b1, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0);
    first_valid_check("wrap_first_addr", 32'hFFFF_FFF8);
    for (int i = 0; i < 12; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit          redir;
    logic [31:0] target;
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      redir  = $urandom_range(99) < 3;
      target = $urandom;
      drive_cycle(redir, target, $urandom_range(99) < 70, $urandom_range(99) < 20,
                  redir && (pend.size() < DEPTH) && ($urandom_range(1) == 1));
    end
  endtask

  task automatic test_reset_midstream();
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (instr_req_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req: got %b expected 0", instr_req_o); end
    checks++;
    if (instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", instr_valid_o); end
    checks++;
    if (cycle_counter_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cycle: got %b expected 0", cycle_counter_o); end
    checks++;
    if (instr_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_instr: got %h expected 0", instr_o); end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== BOOT) begin
      errors++;
      $display("[TB] FAIL midrst_boot_req: got req %b addr %h expected 1 %h", instr_req_o, instr_addr_o, BOOT);
    end
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    consumed = 0;
    cycle_no = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_multicycle();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
